// File: rtl/scan_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_mux_reg
//  Description : Registered N:1 channel multiplexer with manual select and
//                auto-scan modes. In scan mode each channel is held for
//                DWELL cycles before advancing. Outputs the selected data,
//                the channel index, a channel-change pulse and a scan-wrap
//                pulse.
//                Optional macro MUX_CH_MASK_EN adds a per-channel enable mask
//                (ch_mask); disabled channels are skipped by the scan and
//                read as zero in manual mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_mux_reg #(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [N_CH*W-1:0] data_in,
`ifdef MUX_CH_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic [W-1:0]      y,
    output logic [SW-1:0]     ch,
    output logic              step,
    output logic              wrap
);

    localparam int c_NCH_P2 = 2 ** SW;
    localparam int c_DW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);
    localparam logic [c_DW-1:0] c_DWELL_ONE  = c_DW'(1);

    localparam logic [0:0] c_ST_MANUAL = 1'b0;
    localparam logic [0:0] c_ST_SCAN   = 1'b1;

    logic [0:0]      r_state;
    logic [SW-1:0]   r_ch;
    logic [c_DW-1:0] r_dwell;
    logic [W-1:0]    r_y;
    logic            r_step;
    logic            r_wrap;

    logic [N_CH-1:0]     w_en;
    logic [c_NCH_P2-1:0] w_en_ext;
    logic                w_any_en;
    logic [W-1:0]        w_chan [c_NCH_P2];

    logic [0:0]      w_state_next;
    logic [SW-1:0]   w_ch_next;
    logic [c_DW-1:0] w_dwell_next;
    logic            w_y_en;
    logic [W-1:0]    w_y_next;
    logic            w_wrap_next;
    logic [SW-1:0]   w_scan_ch;
    logic [SW-1:0]   w_low_ch;
    logic            w_low_found;

`ifdef MUX_CH_MASK_EN
    assign w_en = ch_mask;
`else
    assign w_en = '1;
`endif

    // Pad the enable vector and channel array to a power of two so any
    // SW-bit index lands on a defined (disabled, zero) entry.
    assign w_en_ext = c_NCH_P2'(w_en);
    assign w_any_en = |w_en;

    for (genvar i = 0; i < c_NCH_P2; i++) begin : g_chan
        if (i < N_CH) begin : g_real
            assign w_chan[i] = data_in[i*W +: W];
        end else begin : g_pad
            assign w_chan[i] = '0;
        end
    end

    // Next-state, next-channel and dwell decisions for both modes.
    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        w_dwell_next = r_dwell;
        w_y_en       = 1'b0;
        w_wrap_next  = 1'b0;

        // Next enabled channel after r_ch, searching with wrap-around;
        // scanning downwards leaves the nearest one selected.
        w_scan_ch = r_ch;
        for (int k = N_CH; k >= 1; k--) begin
            if (w_en_ext[SW'((int'(r_ch) + k) % N_CH)]) begin
                w_scan_ch = SW'((int'(r_ch) + k) % N_CH);
            end
        end

        // Lowest enabled channel, used as the scan entry point.
        w_low_ch    = '0;
        w_low_found = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_en_ext[SW'(k)]) begin
                w_low_ch    = SW'(k);
                w_low_found = 1'b1;
            end
        end

        if (mode) begin
            w_state_next = c_ST_SCAN;
            if (r_state == c_ST_MANUAL) begin
                w_dwell_next = '0;
                if (w_low_found) begin
                    w_ch_next = w_low_ch;
                    w_y_en    = 1'b1;
                end
            end else if (!w_any_en) begin
                // Nothing to scan: park on the current index with y at zero.
                w_dwell_next = '0;
            end else if (r_dwell == c_DWELL_LAST) begin
                w_dwell_next = '0;
                w_ch_next    = w_scan_ch;
                w_wrap_next  = (w_scan_ch < r_ch);
                w_y_en       = 1'b1;
            end else begin
                w_dwell_next = r_dwell + c_DWELL_ONE;
                w_y_en       = w_en_ext[r_ch];
            end
        end else begin
            // Mode change wins over a coincident dwell expiry.
            w_state_next = c_ST_MANUAL;
            w_dwell_next = '0;
            if ((int'(sel) < N_CH) && w_en_ext[sel]) begin
                w_ch_next = sel;
                w_y_en    = 1'b1;
            end
        end

        w_y_next = w_y_en ? w_chan[w_ch_next] : '0;
    end

    // State and output registers; y always reflects the channel loaded here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_MANUAL;
            r_ch    <= '0;
            r_dwell <= '0;
            r_y     <= '0;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ch    <= w_ch_next;
            r_dwell <= w_dwell_next;
            r_y     <= w_y_next;
            r_step  <= (w_ch_next != r_ch);
            r_wrap  <= w_wrap_next;
        end
    end

    assign y    = r_y;
    assign ch   = r_ch;
    assign step = r_step;
    assign wrap = r_wrap;

endmodule
`default_nettype wire
